// File: rtl/full_adder_pkg.sv
// -----------------------------------------------------------------------------
// full_adder_pkg
// Shared constants and helpers for the ripple-carry adder slice.
//   DEFAULT_WIDTH  default operand/sum width
//   DEFAULT_CNT_W  default width of the carry-out event counter
//   signed_ovf()   signed overflow from the carries around the MSB cell
// -----------------------------------------------------------------------------
package full_adder_pkg;

   localparam int DEFAULT_WIDTH = 1;
   localparam int DEFAULT_CNT_W = 8;

   // Two's-complement overflow: the MSB cell saw a carry in that differs from
   // its carry out.
   function automatic logic signed_ovf(input logic c_into_msb, input logic c_out_msb);
      return c_into_msb ^ c_out_msb;
   endfunction

endpackage

// File: rtl/full_adder_if.sv
// -----------------------------------------------------------------------------
// full_adder_if
// Bundles the operand inputs and every result output of full_adder.
//   a, b, ci            operands and carry in (driven by the master)
//   s, co, ovf          combinational result
//   s_q, co_q, ovf_q    registered result
//   co_count            saturating count of edges with co=1
// Modports: master drives operands, slave (the adder) drives results.
// -----------------------------------------------------------------------------
interface full_adder_if
   import full_adder_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH,
   parameter int CNT_W = DEFAULT_CNT_W
);

   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             ci;
   logic [WIDTH-1:0] s;
   logic             co;
   logic             ovf;
   logic [WIDTH-1:0] s_q;
   logic             co_q;
   logic             ovf_q;
   logic [CNT_W-1:0] co_count;

   modport master (
      output a, b, ci,
      input  s, co, ovf, s_q, co_q, ovf_q, co_count
   );

   modport slave (
      input  a, b, ci,
      output s, co, ovf, s_q, co_q, ovf_q, co_count
   );

endinterface

// File: rtl/full_adder_fa_cell.sv
// -----------------------------------------------------------------------------
// fa_cell
// One-bit full adder, the building block of the ripple chain.
//   a, b  operand bits
//   ci    carry in
//   s     sum bit
//   co    carry out (majority of a, b, ci)
// -----------------------------------------------------------------------------
module fa_cell (
   input  logic a,
   input  logic b,
   input  logic ci,
   output logic s,
   output logic co
);

   assign s  = a ^ b ^ ci;
   assign co = (a & b) | (a & ci) | (b & ci);

endmodule

// File: rtl/full_adder.sv
// -----------------------------------------------------------------------------
// full_adder
// Parameterizable ripple-carry adder with registered result copies, a signed
// overflow flag and a saturating carry-out event counter.
//   clock     rising-edge clock for all registers
//   reset_n   asynchronous active-low reset of the registered outputs
//   bus       full_adder_if.slave: a, b, ci in; s, co, ovf (combinational),
//             s_q, co_q, ovf_q (one cycle later), co_count out
// -----------------------------------------------------------------------------
module full_adder
   import full_adder_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH,
   parameter int CNT_W = DEFAULT_CNT_W
)(
   input  logic       clock,
   input  logic       reset_n,
   full_adder_if.slave bus
);

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   logic [WIDTH:0]   c_s;        // c_s[i] is the carry into cell i
   logic [WIDTH-1:0] s_s;
   logic             co_s;
   logic             ovf_s;
   logic [WIDTH-1:0] s_q_r;
   logic             co_q_r;
   logic             ovf_q_r;
   logic [CNT_W-1:0] cnt_r;
   logic [CNT_W-1:0] cnt_nxt_s;

   assign c_s[0] = bus.ci;

   // Ripple chain, LSB first; each cell feeds its carry to the next.
   for (genvar i = 0; i < WIDTH; i++) begin : g_cell
      fa_cell u_cell (
         .a  (bus.a[i]),
         .b  (bus.b[i]),
         .ci (c_s[i]),
         .s  (s_s[i]),
         .co (c_s[i+1])
      );
   end

   assign co_s  = c_s[WIDTH];
   // The carry into the MSB cell is tapped here; at WIDTH=1 that is ci itself.
   assign ovf_s = signed_ovf(c_s[WIDTH-1], c_s[WIDTH]);

   assign bus.s   = s_s;
   assign bus.co  = co_s;
   assign bus.ovf = ovf_s;

   // Next counter value: count carry-out edges, sticking at all-ones.
   always_comb begin
      cnt_nxt_s = cnt_r;
      if ((co_s == 1'b1) && (cnt_r != CNT_MAX)) begin
         cnt_nxt_s = cnt_r + CNT_W'(1);
      end else begin
         cnt_nxt_s = cnt_r;
      end
   end

   // Result and counter registers, cleared asynchronously by reset_n.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         s_q_r   <= '0;
         co_q_r  <= 1'b0;
         ovf_q_r <= 1'b0;
         cnt_r   <= '0;
      end else begin
         s_q_r   <= s_s;
         co_q_r  <= co_s;
         ovf_q_r <= ovf_s;
         cnt_r   <= cnt_nxt_s;
      end
   end

   assign bus.s_q      = s_q_r;
   assign bus.co_q     = co_q_r;
   assign bus.ovf_q    = ovf_q_r;
   assign bus.co_count = cnt_r;

endmodule

// File: tb/tb_full_adder.sv
// -----------------------------------------------------------------------------
// tb_full_adder
// Drives a WIDTH=1/CNT_W=2 adder and a WIDTH=4/CNT_W=8 adder side by side and
// compares every output against an arithmetic reference model.
// -----------------------------------------------------------------------------
module tb_full_adder;

   logic clk;
   logic rst_n;

   full_adder_if #(.WIDTH(1), .CNT_W(2)) if1 ();
   full_adder_if #(.WIDTH(4), .CNT_W(8)) if4 ();

   full_adder #(.WIDTH(1), .CNT_W(2)) u1 (.clock(clk), .reset_n(rst_n), .bus(if1));
   full_adder #(.WIDTH(4), .CNT_W(8)) u4 (.clock(clk), .reset_n(rst_n), .bus(if4));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int ncmp = 0;
   int nerr = 0;

   // expected registered state of each adder
   int m1_sq, m1_coq, m1_ovfq, m1_cnt;
   int m4_sq, m4_coq, m4_ovfq, m4_cnt;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      ncmp++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference: plain integer addition, signed range test for overflow.
   function automatic void model(input int w, input int a, input int b, input int ci,
                                 output int s, output int co, output int ovf);
      int sum, half, sa, sb, ssum;
      sum  = a + b + ci;
      s    = sum % (1 << w);
      co   = sum >> w;
      half = 1 << (w - 1);
      sa   = (a >= half) ? a - (1 << w) : a;
      sb   = (b >= half) ? b - (1 << w) : b;
      ssum = sa + sb + ci;
      ovf  = ((ssum > half - 1) || (ssum < -half)) ? 1 : 0;
   endfunction

   task automatic set1(input int a, input int b, input int ci);
      if1.a  = a[0:0];
      if1.b  = b[0:0];
      if1.ci = ci[0];
   endtask

   task automatic set4(input int a, input int b, input int ci);
      if4.a  = a[3:0];
      if4.b  = b[3:0];
      if4.ci = ci[0];
   endtask

   task automatic check_comb(input string tag);
      int s, co, ovf;
      #1;
      model(1, int'(if1.a), int'(if1.b), int'(if1.ci), s, co, ovf);
      chk({tag, ".w1.s"},   32'(if1.s),   32'(s));
      chk({tag, ".w1.co"},  32'(if1.co),  32'(co));
      chk({tag, ".w1.ovf"}, 32'(if1.ovf), 32'(ovf));
      model(4, int'(if4.a), int'(if4.b), int'(if4.ci), s, co, ovf);
      chk({tag, ".w4.s"},   32'(if4.s),   32'(s));
      chk({tag, ".w4.co"},  32'(if4.co),  32'(co));
      chk({tag, ".w4.ovf"}, 32'(if4.ovf), 32'(ovf));
   endtask

   task automatic check_regs(input string tag);
      chk({tag, ".w1.s_q"},   32'(if1.s_q),      32'(m1_sq));
      chk({tag, ".w1.co_q"},  32'(if1.co_q),     32'(m1_coq));
      chk({tag, ".w1.ovf_q"}, 32'(if1.ovf_q),    32'(m1_ovfq));
      chk({tag, ".w1.cnt"},   32'(if1.co_count), 32'(m1_cnt));
      chk({tag, ".w4.s_q"},   32'(if4.s_q),      32'(m4_sq));
      chk({tag, ".w4.co_q"},  32'(if4.co_q),     32'(m4_coq));
      chk({tag, ".w4.ovf_q"}, 32'(if4.ovf_q),    32'(m4_ovfq));
      chk({tag, ".w4.cnt"},   32'(if4.co_count), 32'(m4_cnt));
   endtask

   task automatic model_clear();
      m1_sq = 0; m1_coq = 0; m1_ovfq = 0; m1_cnt = 0;
      m4_sq = 0; m4_coq = 0; m4_ovfq = 0; m4_cnt = 0;
   endtask

   // One rising edge: update the model from the inputs present at the edge.
   task automatic tick(input string tag);
      int s, co, ovf;
      @(posedge clk);
      if (rst_n) begin
         model(1, int'(if1.a), int'(if1.b), int'(if1.ci), s, co, ovf);
         m1_sq = s; m1_coq = co; m1_ovfq = ovf;
         if (co == 1 && m1_cnt < 3) m1_cnt++;
         model(4, int'(if4.a), int'(if4.b), int'(if4.ci), s, co, ovf);
         m4_sq = s; m4_coq = co; m4_ovfq = ovf;
         if (co == 1 && m4_cnt < 255) m4_cnt++;
      end else begin
         model_clear();
      end
      #1;
      check_regs(tag);
   endtask

   initial begin
      int sat_exp [5];
      sat_exp = '{1, 2, 3, 3, 3};

      // reset state
      rst_n = 1'b0;
      set1(0, 0, 0);
      set4(0, 0, 0);
      model_clear();
      #12;
      check_regs("rst");
      check_comb("rst");

      // release with a=1,b=1,ci=0 on the 1-bit adder
      set1(1, 1, 0);
      rst_n = 1'b1;
      check_comb("rel");
      tick("rel");
      chk("rel.sq_const",  32'(if1.s_q),      32'd0);
      chk("rel.coq_const", 32'(if1.co_q),     32'd1);
      chk("rel.cnt_const", 32'(if1.co_count), 32'd1);

      // exhaustive WIDTH=1 sweep as a 3-bit counter (a,b,ci)
      for (int v = 0; v < 8; v++) begin
         set1((v >> 2) & 1, (v >> 1) & 1, v & 1);
         check_comb("sweep");
         tick("sweep");
      end

      // WIDTH=4 directed vectors
      set4(4'hF, 4'h1, 0); check_comb("d_f1"); tick("d_f1");
      chk("d_f1.s_const", 32'(if4.s_q), 32'h0);
      set4(4'h7, 4'h1, 0); check_comb("d_71"); tick("d_71");
      chk("d_71.s_const",   32'(if4.s_q),   32'h8);
      chk("d_71.ovf_const", 32'(if4.ovf_q), 32'd1);
      set4(4'h8, 4'h8, 1); check_comb("d_881"); tick("d_881");
      set4(4'h0, 4'h0, 1); check_comb("d_001"); tick("d_001");

      // build up s_q=8 and co_count=5 on the 4-bit adder after a fresh reset
      rst_n = 1'b0;
      #1;
      model_clear();
      check_regs("rst2");
      rst_n = 1'b1;
      set1(0, 0, 0);
      for (int k = 0; k < 5; k++) begin
         set4(4'hF, 4'h1, 0);
         tick("build");
      end
      set4(4'h7, 4'h1, 0);
      tick("build8");
      chk("build.cnt5", 32'(if4.co_count), 32'd5);

      // mid-cycle asynchronous reset; combinational path keeps tracking
      #2;
      rst_n = 1'b0;
      model_clear();
      #1;
      check_regs("async_rst");
      set4(4'h9, 4'h9, 0);
      set1(1, 0, 1);
      check_comb("rst_comb");
      tick("rst_hold");
      #2;
      rst_n = 1'b1;

      // saturation of the 2-bit counter
      set4(0, 0, 0);
      set1(1, 1, 0);
      for (int k = 0; k < 5; k++) begin
         tick("sat");
         chk("sat.const", 32'(if1.co_count), 32'(sat_exp[k]));
      end
      set1(0, 1, 0);
      tick("sat_hold");
      tick("sat_hold");
      chk("sat_hold.const", 32'(if1.co_count), 32'd3);

      // randomized operands on both adders
      for (int k = 0; k < 300; k++) begin
         set1($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1));
         set4($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 1));
         check_comb("rnd");
         tick("rnd");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
      $finish;
   end

endmodule
